// File: rtl/uart_frame_gen_pkg.sv
// Shared types and helpers for the UART frame generator.
// Frame configuration is captured once per frame so mid-frame input changes are ignored.
package uart_frame_gen_pkg;

  localparam int unsigned MaxCntW = 32;
  localparam int unsigned BitCntW = 5;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  typedef struct packed {
    logic [MaxCntW-1:0] div;
    logic               parity_en;
    logic               parity_odd;
    logic               stop2;
    logic               inj_par;
    logic               inj_frm;
  } frame_cfg_t;

  // Break is held low for twice the nominal frame length; returns the down-counter reload.
  function automatic logic [BitCntW-1:0] break_reload(input int unsigned data_width,
                                                      input logic        parity_en,
                                                      input logic        stop2);
    int unsigned periods;
    periods = 2 * (data_width + 2 + 32'(parity_en) + 32'(stop2));
    return BitCntW'(periods - 1);
  endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with optional pass-through when empty.
// Occupancy is tracked by an explicit counter so non-power-of-two depths work.
module prim_fifo_sync #(
  parameter int unsigned Width  = 16,
  parameter bit          Pass   = 1'b1,
  parameter int unsigned Depth  = 4,
  localparam int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic [DepthW-1:0] depth_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [DepthW-1:0] cnt_q, cnt_d;
  logic              empty, full, pass_thru, do_write, do_read;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == DepthW'(Depth));
    pass_thru = Pass && empty;
    wready_o  = !full;
    rvalid_o  = !empty || (pass_thru && wvalid_i);
    rdata_o   = pass_thru ? wdata_i : mem_q[rptr_q];
    depth_o   = cnt_q;
    // A pass-through beat consumed in the same cycle never touches storage.
    do_write  = wvalid_i && !full && !(pass_thru && rready_i);
    do_read   = rready_i && !empty;

    wptr_d = do_write ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_read  ? ptr_inc(rptr_q) : rptr_q;
    unique case ({do_write, do_read})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_frame_gen.sv
// UART serial stimulus generator: turns a buffered byte stream into framed serial data,
// with run-time baud divisor, parity, stop bits, error injection and line break.
module uart_frame_gen
  import uart_frame_gen_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned CntW      = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [DataWidth-1:0]               data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [CntW-1:0]                    baud_div_i,
  input  logic                               parity_en_i,
  input  logic                               parity_odd_i,
  input  logic                               stop2_i,
  input  logic                               inj_parity_err_i,
  input  logic                               inj_frame_err_i,
  input  logic                               break_req_i,
  output logic                               tx_o,
  output logic                               busy_o,
  output logic                               frame_done_o,
  output logic [$clog2(FifoDepth+1)-1:0]     fifo_depth_o
);

  state_e               state_q, state_d;
  frame_cfg_t           cfg_q, cfg_d, cfg_new;
  logic [MaxCntW-1:0]   cnt_q, cnt_d;
  logic [BitCntW-1:0]   bit_q, bit_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 par_q, par_d;

  logic                 fifo_rvalid, fifo_rready;
  logic [DataWidth-1:0] fifo_rdata;
  logic                 tick, fetch;

  prim_fifo_sync #(
    .Width (DataWidth),
    .Pass  (1'b0),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (valid_i),
    .wready_o (ready_o),
    .wdata_i  (data_i),
    .rvalid_o (fifo_rvalid),
    .rready_i (fifo_rready),
    .rdata_o  (fifo_rdata),
    .depth_o  (fifo_depth_o)
  );

  assign busy_o = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    fifo_rready  = 1'b0;
    frame_done_o = 1'b0;
    tx_o         = 1'b1;
    fetch        = 1'b0;

    cfg_new.div        = MaxCntW'(baud_div_i);
    cfg_new.parity_en  = parity_en_i;
    cfg_new.parity_odd = parity_odd_i;
    cfg_new.stop2      = stop2_i;
    cfg_new.inj_par    = inj_parity_err_i;
    cfg_new.inj_frm    = inj_frame_err_i;

    tick = (cnt_q == '0);
    if (!tick) begin
      cnt_d = cnt_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (break_req_i) begin
          state_d       = StBreak;
          cfg_d         = cfg_new;
          cfg_d.stop2   = 1'b0;
          cfg_d.inj_frm = 1'b0;
          cnt_d         = cfg_new.div;
          bit_d         = break_reload(DataWidth, parity_en_i, stop2_i);
        end else begin
          fetch = fifo_rvalid;
        end
      end
      StStart: begin
        tx_o = 1'b0;
        if (tick) begin
          state_d = StData;
          bit_d   = '0;
          cnt_d   = cfg_q.div;
        end
      end
      StData: begin
        tx_o = shift_q[0];
        if (tick) begin
          cnt_d   = cfg_q.div;
          shift_d = shift_q >> 1;
          if (bit_q == BitCntW'(DataWidth - 1)) begin
            state_d = cfg_q.parity_en ? StParity : StStop;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        tx_o = par_q ^ cfg_q.parity_odd ^ cfg_q.inj_par;
        if (tick) begin
          state_d = StStop;
          bit_d   = '0;
          cnt_d   = cfg_q.div;
        end
      end
      StStop: begin
        tx_o = !((bit_q == '0) && cfg_q.inj_frm);
        if (tick) begin
          if ((bit_q == '0) && cfg_q.stop2) begin
            bit_d = BitCntW'(1);
            cnt_d = cfg_q.div;
          end else begin
            // Chain straight into the next buffered frame so there is no idle gap.
            frame_done_o = 1'b1;
            state_d      = StIdle;
            fetch        = fifo_rvalid;
          end
        end
      end
      StBreak: begin
        tx_o = 1'b0;
        if (tick) begin
          cnt_d = cfg_q.div;
          if (bit_q == '0) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (fetch) begin
      fifo_rready = 1'b1;
      state_d     = StStart;
      cfg_d       = cfg_new;
      cnt_d       = cfg_new.div;
      shift_d     = fifo_rdata;
      par_d       = ^fifo_rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cfg_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_gen.sv
// Directed bench for uart_frame_gen: outputs are logged every falling edge and
// compared against hand-built frames.
module tb_uart_frame_gen;

  localparam int unsigned HN = 2048;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [15:0] baud_div_i;
  logic       parity_en_i, parity_odd_i, stop2_i;
  logic       inj_parity_err_i, inj_frame_err_i, break_req_i;
  logic       tx_o, busy_o, frame_done_o;
  logic [2:0] fifo_depth_o;

  int total = 0;
  int bad   = 0;
  int pcyc  = 0;

  logic tx_h [HN];
  logic done_h [HN];
  logic busy_h [HN];
  logic rdy_h [HN];

  uart_frame_gen #(
    .DataWidth (8),
    .FifoDepth (4),
    .CntW      (16)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .data_i           (data_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .baud_div_i       (baud_div_i),
    .parity_en_i      (parity_en_i),
    .parity_odd_i     (parity_odd_i),
    .stop2_i          (stop2_i),
    .inj_parity_err_i (inj_parity_err_i),
    .inj_frame_err_i  (inj_frame_err_i),
    .break_req_i      (break_req_i),
    .tx_o             (tx_o),
    .busy_o           (busy_o),
    .frame_done_o     (frame_done_o),
    .fifo_depth_o     (fifo_depth_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) pcyc <= pcyc + 1;

  always @(negedge clk_i) begin
    if (pcyc < HN) begin
      tx_h[pcyc]   <= tx_o;
      done_h[pcyc] <= frame_done_o;
      busy_h[pcyc] <= busy_o;
      rdy_h[pcyc]  <= ready_o;
    end
  end

  // Serial bit k of a frame with 8 data bits.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic pe,
                                             input logic odd, input logic injp,
                                             input logic injf, input logic s2);
    logic [15:0] fb;
    int n;
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = d[i];
    n = 9;
    if (pe) begin
      fb[n] = (^d) ^ odd ^ injp;
      n++;
    end
    fb[n] = ~injf;
    if (s2) fb[n+1] = 1'b1;
    return fb;
  endfunction

  task automatic push_byte(input logic [7:0] d);
    data_i  = d;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    data_i = '0; valid_i = 1'b0; baud_div_i = '0;
    parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0;
    inj_parity_err_i = 1'b0; inj_frame_err_i = 1'b0; break_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", frame_done_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
    total++; if (fifo_depth_o !== 3'd0) begin bad++; $display("FAIL rst_depth got=%0d exp=0", fifo_depth_o); end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_single_frame;
    logic [15:0] fb;
    int base;
    baud_div_i = 16'd15; parity_en_i = 1'b0; stop2_i = 1'b0;
    fb = frame_bits(8'hAF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (fb[9:0] !== 10'b11_0101_1110) begin bad++; $display("FAIL t1_model got=%b exp=1101011110", fb[9:0]); end
    push_byte(8'hAF);
    base = pcyc + 1;
    total++; if (fifo_depth_o !== 3'd1) begin bad++; $display("FAIL t1_depth got=%0d exp=1", fifo_depth_o); end
    @(negedge clk_i);
    // Changed after the frame has started: must not disturb it.
    baud_div_i = 16'd3; parity_en_i = 1'b1; stop2_i = 1'b1;
    repeat (163) @(negedge clk_i);
    for (int i = 0; i < 160; i++) begin
      total++;
      if (tx_h[base+i] !== fb[i/16]) begin
        bad++; $display("FAIL t1_tx cyc=%0d got=%b exp=%b", i, tx_h[base+i], fb[i/16]);
      end
    end
    for (int i = 0; i <= 160; i++) begin
      total++;
      if (done_h[base+i] !== (i == 159)) begin
        bad++; $display("FAIL t1_done cyc=%0d got=%b exp=%b", i, done_h[base+i], (i == 159));
      end
    end
    total++; if (busy_h[base] !== 1'b1) begin bad++; $display("FAIL t1_busy_start got=%b exp=1", busy_h[base]); end
    total++; if (busy_h[base+160] !== 1'b0) begin bad++; $display("FAIL t1_busy_end got=%b exp=0", busy_h[base+160]); end
    total++; if (tx_h[base-1] !== 1'b1) begin bad++; $display("FAIL t1_pre_idle got=%b exp=1", tx_h[base-1]); end
  endtask

  task automatic test_parity;
    logic odd_t [3] = '{1'b0, 1'b1, 1'b0};
    logic inj_t [3] = '{1'b0, 1'b0, 1'b1};
    logic exp_p [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] fb;
    int base;
    for (int c = 0; c < 3; c++) begin
      baud_div_i = 16'd1; parity_en_i = 1'b1; stop2_i = 1'b0;
      parity_odd_i = odd_t[c]; inj_parity_err_i = inj_t[c];
      fb = frame_bits(8'hAF, 1'b1, odd_t[c], inj_t[c], 1'b0, 1'b0);
      push_byte(8'hAF);
      base = pcyc + 1;
      @(negedge clk_i);
      inj_parity_err_i = 1'b0; parity_odd_i = 1'b0;
      repeat (24) @(negedge clk_i);
      total++;
      if (tx_h[base+18] !== exp_p[c]) begin
        bad++; $display("FAIL t2_parity case=%0d got=%b exp=%b", c, tx_h[base+18], exp_p[c]);
      end
      for (int i = 0; i < 22; i++) begin
        total++;
        if (tx_h[base+i] !== fb[i/2]) begin
          bad++; $display("FAIL t2_tx case=%0d cyc=%0d got=%b exp=%b", c, i, tx_h[base+i], fb[i/2]);
        end
      end
      total++; if (done_h[base+21] !== 1'b1) begin bad++; $display("FAIL t2_done case=%0d got=%b exp=1", c, done_h[base+21]); end
    end
    parity_en_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] d_t [6] = '{8'h3C, 8'hAF, 8'hAA, 8'h55, 8'h00, 8'hFF};
    logic [15:0] fb;
    int base0;
    int g;
    baud_div_i = 16'd1; parity_en_i = 1'b0; stop2_i = 1'b0;
    push_byte(d_t[0]);
    base0 = pcyc + 1;
    @(negedge clk_i);
    for (int k = 1; k <= 4; k++) begin
      data_i = d_t[k]; valid_i = 1'b1;
      @(negedge clk_i);
    end
    data_i = d_t[5];
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL t3_ready_full got=%b exp=0", ready_o); end
    total++; if (fifo_depth_o !== 3'd4) begin bad++; $display("FAIL t3_depth_full got=%0d exp=4", fifo_depth_o); end
    g = 0;
    while (!ready_o && g < 200) begin
      @(negedge clk_i);
      g++;
    end
    total++; if (g >= 200) begin bad++; $display("FAIL t3_ready_timeout got=%0d exp<200", g); end
    @(negedge clk_i);
    valid_i = 1'b0;
    while (pcyc < base0 + 124) @(negedge clk_i);
    total++; if (rdy_h[base0+19] !== 1'b0) begin bad++; $display("FAIL t3_ready_pre_pop got=%b exp=0", rdy_h[base0+19]); end
    total++; if (rdy_h[base0+20] !== 1'b1) begin bad++; $display("FAIL t3_ready_post_pop got=%b exp=1", rdy_h[base0+20]); end
    for (int i = 0; i < 120; i++) begin
      fb = frame_bits(d_t[i/20], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (tx_h[base0+i] !== fb[(i%20)/2]) begin
        bad++; $display("FAIL t3_tx cyc=%0d got=%b exp=%b", i, tx_h[base0+i], fb[(i%20)/2]);
      end
      total++;
      if (busy_h[base0+i] !== 1'b1) begin
        bad++; $display("FAIL t3_busy cyc=%0d got=%b exp=1", i, busy_h[base0+i]);
      end
      total++;
      if (done_h[base0+i] !== ((i % 20) == 19)) begin
        bad++; $display("FAIL t3_done cyc=%0d got=%b exp=%b", i, done_h[base0+i], ((i % 20) == 19));
      end
    end
    total++; if (busy_h[base0+120] !== 1'b0) begin bad++; $display("FAIL t3_busy_end got=%b exp=0", busy_h[base0+120]); end
  endtask

  task automatic test_errors;
    logic [15:0] fb;
    int base;
    baud_div_i = 16'd0; parity_en_i = 1'b0; stop2_i = 1'b1; inj_frame_err_i = 1'b1;
    push_byte(8'h5A);
    base = pcyc + 1;
    @(negedge clk_i);
    inj_frame_err_i = 1'b0;
    repeat (14) @(negedge clk_i);
    fb = frame_bits(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      total++;
      if (tx_h[base+i] !== fb[i]) begin
        bad++; $display("FAIL t4_tx cyc=%0d got=%b exp=%b", i, tx_h[base+i], fb[i]);
      end
    end
    total++; if (tx_h[base+9] !== 1'b0) begin bad++; $display("FAIL t4_stop1 got=%b exp=0", tx_h[base+9]); end
    total++; if (tx_h[base+10] !== 1'b1) begin bad++; $display("FAIL t4_stop2 got=%b exp=1", tx_h[base+10]); end
    total++; if (done_h[base+10] !== 1'b1) begin bad++; $display("FAIL t4_done got=%b exp=1", done_h[base+10]); end
    total++; if (done_h[base+9] !== 1'b0) begin bad++; $display("FAIL t4_done_early got=%b exp=0", done_h[base+9]); end
    total++; if (busy_h[base+11] !== 1'b0) begin bad++; $display("FAIL t4_len got=%b exp=0", busy_h[base+11]); end
    push_byte(8'h5A);
    base = pcyc + 1;
    repeat (14) @(negedge clk_i);
    total++; if (tx_h[base+9] !== 1'b1) begin bad++; $display("FAIL t4_noinj_stop1 got=%b exp=1", tx_h[base+9]); end
    total++; if (done_h[base+10] !== 1'b1) begin bad++; $display("FAIL t4_noinj_done got=%b exp=1", done_h[base+10]); end
    stop2_i = 1'b0;
  endtask

  task automatic test_break;
    logic [15:0] fb;
    logic        exp;
    int base;
    baud_div_i = 16'd1; parity_en_i = 1'b0; stop2_i = 1'b0;
    break_req_i = 1'b1; data_i = 8'h12; valid_i = 1'b1;
    @(negedge clk_i);
    break_req_i = 1'b0; valid_i = 1'b0;
    base = pcyc;
    total++; if (fifo_depth_o !== 3'd1) begin bad++; $display("FAIL t5_held got=%0d exp=1", fifo_depth_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL t5_busy got=%b exp=1", busy_o); end
    repeat (66) @(negedge clk_i);
    fb = frame_bits(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 62; i++) begin
      if (i < 40) exp = 1'b0;
      else if (i < 42) exp = 1'b1;
      else exp = fb[(i-42)/2];
      total++;
      if (tx_h[base+i] !== exp) begin
        bad++; $display("FAIL t5_tx cyc=%0d got=%b exp=%b", i, tx_h[base+i], exp);
      end
    end
    total++; if (done_h[base+41] !== 1'b1) begin bad++; $display("FAIL t5_break_done got=%b exp=1", done_h[base+41]); end
    total++; if (done_h[base+61] !== 1'b1) begin bad++; $display("FAIL t5_frame_done got=%b exp=1", done_h[base+61]); end
    total++; if (busy_h[base+62] !== 1'b0) begin bad++; $display("FAIL t5_busy_end got=%b exp=0", busy_h[base+62]); end
  endtask

  task automatic test_reset_mid;
    int base;
    int rb;
    int nd;
    int nt;
    baud_div_i = 16'd3; parity_en_i = 1'b0; stop2_i = 1'b0;
    push_byte(8'hAB);
    push_byte(8'h55);
    base = pcyc;
    while (pcyc < base + 13) @(negedge clk_i);
    total++; if (tx_o !== 1'b0) begin bad++; $display("FAIL t6_bit3 got=%b exp=0", tx_o); end
    total++; if (fifo_depth_o !== 3'd1) begin bad++; $display("FAIL t6_depth_pre got=%0d exp=1", fifo_depth_o); end
    #2 rst_ni = 1'b0;
    #1;
    total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL t6_tx_async got=%b exp=1", tx_o); end
    total++; if (fifo_depth_o !== 3'd0) begin bad++; $display("FAIL t6_depth got=%0d exp=0", fifo_depth_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t6_busy got=%b exp=0", busy_o); end
    total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL t6_done got=%b exp=0", frame_done_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    rb = pcyc;
    repeat (32) @(negedge clk_i);
    nd = 0;
    nt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_h[rb+i] !== 1'b0) nd++;
      if (tx_h[rb+i] !== 1'b1) nt++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL t6_no_done got=%0d exp=0", nd); end
    total++; if (nt != 0) begin bad++; $display("FAIL t6_idle_tx got=%0d exp=0", nt); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL t6_ready got=%b exp=1", ready_o); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_errors();
    test_break();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
